// File: rtl/regfile_sb.sv
// regfile_sb: register file with scoreboard for the pipelined core.
//
// Two combinational read ports, two synchronous write ports (port 3 carries
// ALU writeback, port 4 carries load/long-latency writeback), and one busy bit
// per register. The hazard unit uses the busy bits to stall on pending writes.
// Register 0 always reads zero and is never busy.
//
// Parameters:
//   XLEN  data width in bits
//   NREG  number of registers (power of two, >= 2)
//   AW    address width, derived from NREG
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset_n        synchronous active-low reset; clears all state and
//                  discards the writes and issues of that cycle
//   ra1, ra2       read addresses
//   rd1, rd2       read data
//   busy1, busy2   busy bits of ra1 / ra2
//   we3, wa3, wd3  write port 3 (ALU writeback)
//   we4, wa4, wd4  write port 4 (load writeback)
//   iss_en, iss_rd issue strobe; marks iss_rd busy
//   err_conflict   sticky flag: both ports wrote the same nonzero register
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, reads forward the data being written in
//                      the current cycle, and the busy bit of that register
//                      reads 0 unless it is issued again in the same cycle.

module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we3,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we4,
    input  logic [AW-1:0]   wa4,
    input  logic [XLEN-1:0] wd4,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            err_conflict
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic wr3_ok;
    logic wr4_ok;
    logic iss_ok;

    // Writes and issues aimed at register 0 have no effect.
    assign wr3_ok = we3 && (wa3 != '0);
    assign wr4_ok = we4 && (wa4 != '0);
    assign iss_ok = iss_en && (iss_rd != '0);

    // Scoreboard update. The set is applied after the clears so that a new
    // producer issued on the same edge as a completing write keeps the
    // register busy.
    always_comb begin
        busy_next = busy;
        if (wr3_ok) busy_next[wa3] = 1'b0;
        if (wr4_ok) busy_next[wa4] = 1'b0;
        if (iss_ok) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Register array, busy bits and sticky conflict flag. Port 4 is written
    // before port 3 so that port 3 wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            busy         <= '0;
            err_conflict <= 1'b0;
        end else begin
            if (wr4_ok) rf[wa4] <= wd4;
            if (wr3_ok) rf[wa3] <= wd3;
            busy <= busy_next;
            if (wr3_ok && wr4_ok && (wa3 == wa4)) begin
                err_conflict <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding. Port 3 takes priority when both ports target
    // the read address. A forwarded register is no longer waiting on a write,
    // so its busy bit only reads 1 if it is issued again in this cycle.
    // Forwarding is disabled during reset because the write is discarded.
    always_comb begin
        rd1   = (ra1 == '0) ? '0 : rf[ra1];
        busy1 = (ra1 == '0) ? 1'b0 : busy[ra1];
        if (reset_n && (ra1 != '0)) begin
            if (wr3_ok && (wa3 == ra1)) begin
                rd1   = wd3;
                busy1 = iss_en && (iss_rd == ra1);
            end else if (wr4_ok && (wa4 == ra1)) begin
                rd1   = wd4;
                busy1 = iss_en && (iss_rd == ra1);
            end
        end
    end

    always_comb begin
        rd2   = (ra2 == '0) ? '0 : rf[ra2];
        busy2 = (ra2 == '0) ? 1'b0 : busy[ra2];
        if (reset_n && (ra2 != '0)) begin
            if (wr3_ok && (wa3 == ra2)) begin
                rd2   = wd3;
                busy2 = iss_en && (iss_rd == ra2);
            end else if (wr4_ok && (wa4 == ra2)) begin
                rd2   = wd4;
                busy2 = iss_en && (iss_rd == ra2);
            end
        end
    end
`else
    // Reads return stored state only. Address 0 is forced to zero so it
    // reads zero even before the first reset.
    always_comb begin
        rd1   = (ra1 == '0) ? '0 : rf[ra1];
        busy1 = (ra1 == '0) ? 1'b0 : busy[ra1];
        rd2   = (ra2 == '0) ? '0 : rf[ra2];
        busy2 = (ra2 == '0) ? 1'b0 : busy[ra2];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb with default parameters.
// Compiles for either setting of REGFILE_BYPASS_EN; the reference model
// follows the same macro.

module tb_regfile_sb;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        busy1, busy2;
    logic        we3, we4;
    logic [4:0]  wa3, wa4;
    logic [31:0] wd3, wd4;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        err_conflict;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        busy1;
        logic        busy2;
        logic        err;
    } exp_t;

    exp_t sb_queue[$];

    // Reference model of the architectural state.
    logic [31:0] m_rf [32];
    logic [31:0] m_busy;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd1          (rd1),
        .rd2          (rd2),
        .busy1        (busy1),
        .busy2        (busy2),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .we4          (we4),
        .wa4          (wa4),
        .wd4          (wd4),
        .iss_en       (iss_en),
        .iss_rd       (iss_rd),
        .err_conflict (err_conflict)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Expected read value and busy bit for one read address, given the
    // model state and the inputs currently driven.
    function automatic void expRead(input logic [4:0] ra, output logic [31:0] d,
                                    output logic b);
        d = '0;
        b = 1'b0;
        if (ra != 5'd0) begin
            d = m_rf[ra];
            b = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (reset_n) begin
                if (we3 && wa3 == ra) begin
                    d = wd3;
                    b = iss_en && (iss_rd == ra);
                end else if (we4 && wa4 == ra) begin
                    d = wd4;
                    b = iss_en && (iss_rd == ra);
                end
            end
`endif
        end
    endfunction

    // Model update for one rising edge with the current inputs.
    task automatic modelEdge();
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            if (we3 && we4 && wa3 == wa4 && wa3 != 5'd0) m_err = 1'b1;
            if (we4 && wa4 != 5'd0) begin
                m_rf[wa4]   = wd4;
                m_busy[wa4] = 1'b0;
            end
            if (we3 && wa3 != 5'd0) begin
                m_rf[wa3]   = wd3;
                m_busy[wa3] = 1'b0;
            end
            if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic idleInputs();
        reset_n = 1'b1;
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        we4 = 1'b0; wa4 = '0; wd4 = '0;
        iss_en = 1'b0; iss_rd = '0;
    endtask

    // One cycle with the inputs already driven by the caller: push the
    // expected outputs, compare at the falling edge, then advance the model
    // on the rising edge.
    task automatic applyStimulus(input string tag);
        exp_t e;
        exp_t got;
        expRead(ra1, e.rd1, e.busy1);
        expRead(ra2, e.rd2, e.busy2);
        e.err = m_err;
        sb_queue.push_back(e);
        @(negedge clk);
        if (sb_queue.size() == 0) begin
            checkOutput({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_queue.pop_front();
            checkOutput({tag, ".rd1"},   rd1, got.rd1);
            checkOutput({tag, ".rd2"},   rd2, got.rd2);
            checkOutput({tag, ".busy1"}, {31'd0, busy1}, {31'd0, got.busy1});
            checkOutput({tag, ".busy2"}, {31'd0, busy2}, {31'd0, got.busy2});
            checkOutput({tag, ".err"},   {31'd0, err_conflict}, {31'd0, got.err});
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        idleInputs();
        ra1 = '0;
        ra2 = '0;
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;

        // Two reset edges, then read back every address.
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i + 16);
            applyStimulus("reset_read");
        end

        // Both write ports in one cycle, then read back.
        idleInputs();
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
        we4 = 1'b1; wa4 = 5'd7; wd4 = 32'h12345678;
        applyStimulus("dual_write");
        idleInputs();
        ra1 = 5'd5; ra2 = 5'd7;
        applyStimulus("dual_read");

        // Register 0 ignores writes.
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
        we4 = 1'b1; wa4 = 5'd0; wd4 = 32'hFFFFFFFF;
        ra1 = 5'd0;
        applyStimulus("r0_write");
        idleInputs();
        applyStimulus("r0_read");

        // Issue to register 9, observe busy, clear via port 4.
        iss_en = 1'b1; iss_rd = 5'd9; ra1 = 5'd9;
        applyStimulus("issue9");
        idleInputs();
        applyStimulus("busy9");
        we4 = 1'b1; wa4 = 5'd9; wd4 = 32'h00000999;
        applyStimulus("clear9");
        idleInputs();
        applyStimulus("cleared9");

        // Issue and write the same register on one edge: set wins.
        iss_en = 1'b1; iss_rd = 5'd9;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h0000ABCD;
        applyStimulus("set_clear9");
        idleInputs();
        applyStimulus("set_wins9");

        // Collision on register 3: port 3 data stored, flag sticks.
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hA;
        we4 = 1'b1; wa4 = 5'd3; wd4 = 32'hB;
        ra1 = 5'd3;
        applyStimulus("collide3");
        idleInputs();
        for (int i = 0; i < 3; i++) applyStimulus("err_hold");

        // Forwarding case: register 4 busy, then written while being read.
        iss_en = 1'b1; iss_rd = 5'd4; ra1 = 5'd4; ra2 = 5'd4;
        applyStimulus("issue4");
        idleInputs();
        we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h55;
        applyStimulus("bypass4");
        idleInputs();
        applyStimulus("after4");

        // Reset on the same edge as a write and issue to register 6.
        reset_n = 1'b0;
        we3 = 1'b1; wa3 = 5'd6; wd3 = 32'h77;
        iss_en = 1'b1; iss_rd = 5'd6;
        ra1 = 5'd6; ra2 = 5'd3;
        applyStimulus("reset_mid");
        idleInputs();
        applyStimulus("after_reset");

        // Random traffic on a narrow address range to provoke collisions,
        // forwarding and set/clear races, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            we3    = $urandom_range(0, 1) == 1;
            wa3    = 5'($urandom_range(0, 7));
            wd3    = $urandom;
            we4    = $urandom_range(0, 1) == 1;
            wa4    = 5'($urandom_range(0, 7));
            wd4    = $urandom;
            iss_en = $urandom_range(0, 1) == 1;
            iss_rd = 5'($urandom_range(0, 7));
            ra1    = 5'($urandom_range(0, 7));
            ra2    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 7));
            applyStimulus("random");
        end

        if (sb_queue.size() != 0) begin
            checkOutput("queue_drain", 32'(sb_queue.size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
